ddr3_app_emu: RTL

DDR3_APP_EMU -- requirements
Module: ddr3_app_emu

---
 rtl/ddr3_app_pkg.sv | 20 ++
 rtl/ddr3_wdata_fifo.sv | 61 ++++++
 rtl/ddr3_app_emu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ddr3_app_pkg.sv
// Shared constants, FSM state encoding and burst-length helper for the DDR3 application-interface emulator.
package ddr3_app_pkg;

    localparam logic [2:0] WR_CMD = 3'h0;
    localparam logic [2:0] RD_CMD = 3'h1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_READ
    } state_t;

    // Beats per command: one beat carries 8 DQ words.
    function automatic int unsigned calc_bn(input int unsigned burst_len);
        return burst_len / 8;
    endfunction

endpackage

// File: rtl/ddr3_wdata_fifo.sv
// Synchronous write-data FIFO with registered full/empty flags and a first-word-fall-through head.
module ddr3_wdata_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]      count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + 1'b1;
        else if (!push_ok && pop_ok)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == (PW + 1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/ddr3_app_emu.sv
// DDR3 application-interface responder backed by on-chip RAM.
// Optional protocol checker enabled by defining DDR3_EMU_PROTO_CHECK_EN.
module ddr3_app_emu
    import ddr3_app_pkg::*;
#(
    parameter int DQ_WIDTH    = 16,
    parameter int ADDR_WIDTH  = 27,
    parameter int BURST_LEN   = 64,
    parameter int MEM_DEPTH   = 1024,
    parameter int INIT_CYCLES = 16,
    parameter int RD_LATENCY  = 4
) (
    input  logic                    clk_ref,
    input  logic                    rst,
    output logic                    init_done,
    output logic                    cmd_rdy,
    input  logic [2:0]              cmd,
    input  logic                    cmd_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    output logic                    wr_rdy,
    input  logic                    wren,
    input  logic [8*DQ_WIDTH-1:0]   wr_data,
    input  logic                    wr_end,
    output logic [8*DQ_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    proto_err
);
    localparam int BN = int'(calc_bn(BURST_LEN));
    localparam int DW = 8 * DQ_WIDTH;
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int BW = (BN > 1) ? $clog2(BN) : 1;
    localparam int CW = $clog2(INIT_CYCLES + 1);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    state_t          state_reg, state_next;
    logic [CW-1:0]   init_cnt_reg, init_cnt_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [LW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [DW-1:0]   rd_data_reg;
    logic            rd_valid_reg;
    logic [DW-1:0]   ram [MEM_DEPTH];

    logic [DW-1:0]   fifo_head;
    logic            fifo_full, fifo_empty;
    logic            cmd_accept, wr_commit, rd_fire;

    assign init_done  = (state_reg != ST_INIT);
    assign cmd_rdy    = (state_reg == ST_IDLE);
    assign wr_rdy     = init_done && !fifo_full;
    assign cmd_accept = cmd_en && cmd_rdy && (cmd == WR_CMD || cmd == RD_CMD);
    assign wr_commit  = (state_reg == ST_WRITE) && !fifo_empty;
    assign rd_fire    = (state_reg == ST_READ);

    ddr3_wdata_fifo #(
        .WIDTH (DW),
        .DEPTH (2 * BN)
    ) u_wdata_fifo (
        .clk   (clk_ref),
        .srst  (rst),
        .push  (wren && wr_rdy),
        .din   (wr_data),
        .pop   (wr_commit),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == CW'(INIT_CYCLES - 1))
                    state_next = ST_IDLE;
                else
                    init_cnt_next = init_cnt_reg + 1'b1;
            end
            ST_IDLE: begin
                beat_cnt_next = '0;
                wait_cnt_next = '0;
                if (cmd_accept) begin
                    idx_next = addr[3 +: IW];
                    if (cmd == WR_CMD)
                        state_next = ST_WRITE;
                    else
                        state_next = (RD_LATENCY > 1) ? ST_RD_WAIT : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_commit) begin
                    idx_next      = idx_reg + 1'b1;
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == BW'(BN - 1))
                        state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (wait_cnt_reg == LW'(RD_LATENCY - 2))
                    state_next = ST_READ;
                else
                    wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            ST_READ: begin
                idx_next      = idx_reg + 1'b1;
                beat_cnt_next = beat_cnt_reg + 1'b1;
                if (beat_cnt_reg == BW'(BN - 1))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            rd_valid_reg <= rd_fire;
            if (rd_fire)
                rd_data_reg <= ram[idx_reg];
        end
    end

    // RAM has no reset so its contents survive a mid-burst reset.
    always_ff @(posedge clk_ref) begin
        if (wr_commit && !rst)
            ram[idx_reg] <= fifo_head;
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

`ifdef DDR3_EMU_PROTO_CHECK_EN
    logic          proto_err_reg;
    logic [BW-1:0] push_cnt_reg;
    logic          push_fire, push_last;

    assign push_fire = wren && wr_rdy;
    assign push_last = (push_cnt_reg == BW'(BN - 1));

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            proto_err_reg <= 1'b0;
            push_cnt_reg  <= '0;
        end else begin
            if (push_fire)
                push_cnt_reg <= push_last ? '0 : push_cnt_reg + 1'b1;
            if ((cmd_en && !cmd_rdy) ||
                (cmd_en && cmd != WR_CMD && cmd != RD_CMD) ||
                (wren && !wr_rdy) ||
                (push_fire && (wr_end != push_last)) ||
                (wr_end && !push_fire))
                proto_err_reg <= 1'b1;
        end
    end

    assign proto_err = proto_err_reg;
`else
    assign proto_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{addr[2:0], addr[ADDR_WIDTH-1:3+IW], wr_end};

endmodule
